// File: rtl/mem_if_pkg.sv
// Shared definitions for the memory responder: default word width, the
// responder state encoding, the latency counter width and the released-bus word.
package mem_if_pkg;

   localparam int DEF_WORD_SIZE = 16;

   // Wide enough for the largest supported access latency (15 cycles).
   localparam int LAT_CNT_W = 4;

   typedef enum logic [2:0] {
      IDLE,
      RD_WAIT,
      RD_RESP,
      WR_WAIT,
      WR_RESP,
      RELEASE
   } mem_state_t;

   localparam logic [DEF_WORD_SIZE-1:0] HIGHZ_WORD = 'z;

endpackage

// File: rtl/mem_responder_if.sv
// Request/response handshake between a CPU (master) and the memory responder
// (slave). The shared data bus is bidirectional and stays a separate port.
interface mem_responder_if
   import mem_if_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE
);

   logic                 readM;
   logic                 writeM;
   logic [WORD_SIZE-1:0] address;
   logic                 inputReady;
   logic                 ackOutput;
   logic                 err;

   modport master (
      output readM, writeM, address,
      input  inputReady, ackOutput, err
   );

   modport slave (
      input  readM, writeM, address,
      output inputReady, ackOutput, err
   );

endinterface

// File: rtl/mem_array.sv
// Word storage for the responder: synchronous single-port write, combinational
// read from the same index. Contents are never cleared.
module mem_array #(
   parameter int WORD_SIZE = 16,
   parameter int ADDR_BITS = 8
) (
   input  logic                 clk,
   input  logic                 we,
   input  logic [ADDR_BITS-1:0] addr,
   input  logic [WORD_SIZE-1:0] wdata,
   output logic [WORD_SIZE-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_BITS;

   logic [WORD_SIZE-1:0] mem [DEPTH];

   // Commit a write word on the clock edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the CPU readM/writeM handshake. One request at a
// time, fixed access latency, tri-state read data on the shared bus.
// Optional build macro MEM_STATS_EN adds rd_count/wr_count pulse counters.
module mem_responder
   import mem_if_pkg::*;
#(
   parameter int WORD_SIZE = DEF_WORD_SIZE,
   parameter int ADDR_BITS = 8,
   parameter int LATENCY   = 2
) (
   input  logic                 clk,
   input  logic                 reset,
   mem_responder_if.slave       bus,
   inout  wire  [WORD_SIZE-1:0] data
`ifdef MEM_STATS_EN
   ,
   output logic [15:0]          rd_count,
   output logic [15:0]          wr_count
`endif
);

   localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(LATENCY - 1);

   mem_state_t           state;
   mem_state_t           state_next;
   logic [LAT_CNT_W-1:0] lat_cnt;
   logic [ADDR_BITS-1:0] idx;
   logic [WORD_SIZE-1:0] wr_word;
   logic [WORD_SIZE-1:0] rd_word;
   logic [WORD_SIZE-1:0] mem_rdata;
   logic                 rd_txn;
   logic                 err_pulse;
   logic                 bus_drive;
   logic                 mem_we;
   logic                 rd_req;
   logic                 wr_req;

   assign rd_req = bus.readM;
   assign wr_req = bus.writeM;

   // Address bits above the index are deliberately ignored (aliasing).
   if (ADDR_BITS < WORD_SIZE) begin : g_addr_hi
      logic unused_addr_hi;
      assign unused_addr_hi = ^bus.address[WORD_SIZE-1:ADDR_BITS];
   end

   mem_array #(
      .WORD_SIZE (WORD_SIZE),
      .ADDR_BITS (ADDR_BITS)
   ) u_array (
      .clk   (clk),
      .we    (mem_we),
      .addr  (idx),
      .wdata (wr_word),
      .rdata (mem_rdata)
   );

   // Control state: FSM register, latency counter, read-transaction flag, err pulse.
   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         lat_cnt   <= '0;
         rd_txn    <= 1'b0;
         err_pulse <= 1'b0;
      end else begin
         state     <= state_next;
         err_pulse <= (state == IDLE) && rd_req && wr_req;
         if (state == IDLE) begin
            rd_txn <= rd_req && !wr_req;
            if (rd_req ^ wr_req) begin
               lat_cnt <= LAT_LOAD;
            end
         end else if ((state == RD_WAIT || state == WR_WAIT) && lat_cnt != '0) begin
            lat_cnt <= lat_cnt - 1'b1;
         end
      end
   end

   // Datapath capture: request index/write word while idle, read word at the response edge.
   always_ff @(posedge clk) begin
      if (state == IDLE) begin
         idx     <= bus.address[ADDR_BITS-1:0];
         wr_word <= data;
      end
      if (state == RD_WAIT && lat_cnt == '0) begin
         rd_word <= mem_rdata;
      end
   end

   // Next-state, array write enable and bus-drive decode.
   always_comb begin
      state_next = state;
      mem_we     = 1'b0;
      bus_drive  = 1'b0;
      case (state)
         IDLE: begin
            if (rd_req && wr_req) begin
               state_next = RELEASE;
            end else if (rd_req) begin
               state_next = RD_WAIT;
            end else if (wr_req) begin
               state_next = WR_WAIT;
            end
         end
         RD_WAIT: begin
            if (lat_cnt == '0) begin
               state_next = RD_RESP;
            end
         end
         RD_RESP: begin
            bus_drive  = 1'b1;
            state_next = RELEASE;
         end
         WR_WAIT: begin
            if (lat_cnt == '0) begin
               state_next = WR_RESP;
               // A reset on this edge aborts the transaction before it commits.
               mem_we     = !reset;
            end
         end
         WR_RESP: begin
            state_next = RELEASE;
         end
         RELEASE: begin
            bus_drive = rd_txn;
            if (!rd_req && !wr_req) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign bus.inputReady = (state == RD_RESP);
   assign bus.ackOutput  = (state == WR_RESP);
   assign bus.err        = err_pulse;
   assign data           = bus_drive ? rd_word : 'z;

`ifdef MEM_STATS_EN
   // Count completed reads and writes, wrapping at 16 bits.
   always_ff @(posedge clk) begin
      if (reset) begin
         rd_count <= '0;
         wr_count <= '0;
      end else begin
         if (state == RD_RESP) begin
            rd_count <= rd_count + 16'd1;
         end
         if (state == WR_RESP) begin
            wr_count <= wr_count + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Testbench for mem_responder: directed scenarios followed by randomized
// transactions checked against a word-array reference model.
module tb_mem_responder;

   localparam int W   = 16;
   localparam int LAT = 2;

   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_responder_if #(.WORD_SIZE(W)) bus ();

   wire  [W-1:0] data;
   logic         cpu_en;
   logic [W-1:0] cpu_val;

   assign data = cpu_en ? cpu_val : 'z;

`ifdef MEM_STATS_EN
   logic [15:0] rd_count;
   logic [15:0] wr_count;
   int          n_rd;
   int          n_wr;
`endif

   mem_responder #(
      .WORD_SIZE (W),
      .ADDR_BITS (8),
      .LATENCY   (LAT)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .bus      (bus),
      .data     (data)
`ifdef MEM_STATS_EN
      ,
      .rd_count (rd_count),
      .wr_count (wr_count)
`endif
   );

   // Reference model: one word per index, plus the list of indices written so far.
   logic [15:0] model_mem [256];
   logic [7:0]  known_q [$];

   int n_chk  = 0;
   int n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
      end
   endtask

   // The bench drives 0 onto the bus; it reads back 0 only if the DUT has let go.
   task automatic zchk(input string tag);
      cpu_val = '0;
      cpu_en  = 1'b1;
      #1;
      chk(tag, 32'(data), 32'h0);
      cpu_en  = 1'b0;
   endtask

   // One complete CPU transaction, presented at a negedge. Response is expected on
   // the (LAT+1)-th negedge for reads/writes and on the 1st negedge for err.
   task automatic txn(input bit rd, input bit wr, input logic [15:0] addr,
                      input logic [15:0] wval, input int hold);
      int          resp_k;
      int          drop_k;
      int          z_k;
      int          end_k;
      int          rdy_n;
      int          ack_n;
      int          err_n;
      int          at_k;
      int          bad_hold;
      logic [15:0] seen;
      logic [15:0] exp_rd;
      logic [7:0]  i;
      i        = addr[7:0];
      exp_rd   = model_mem[i];
      resp_k   = (rd && wr) ? 1 : LAT + 1;
      drop_k   = resp_k + hold;
      z_k      = (rd && !wr && hold == 0) ? drop_k + 2 : drop_k + 1;
      end_k    = drop_k + 2;
      rdy_n    = 0;
      ack_n    = 0;
      err_n    = 0;
      at_k     = -1;
      bad_hold = 0;
      seen     = '0;
      bus.readM   = rd;
      bus.writeM  = wr;
      bus.address = addr;
      cpu_val     = wval;
      cpu_en      = wr;
      for (int k = 1; k <= end_k; k++) begin
         @(negedge clk);
         if (bus.inputReady) begin
            rdy_n++;
            at_k = k;
            seen = data;
         end
         if (bus.ackOutput) begin
            ack_n++;
            at_k = k;
         end
         if (bus.err) begin
            err_n++;
            at_k = k;
         end
         if (rd && !wr && k >= resp_k && k <= drop_k && data !== exp_rd) begin
            bad_hold++;
         end
         if (k == drop_k) begin
            bus.readM  = 1'b0;
            bus.writeM = 1'b0;
            cpu_en     = 1'b0;
         end
         if (k == z_k) begin
            zchk("bus_release");
         end
      end
      if (rd && wr) begin
         chk("err_pulses", 32'(err_n), 32'd1);
         chk("err_other_pulses", 32'(rdy_n + ack_n), 32'd0);
         chk("err_cycle", 32'(at_k), 32'(resp_k));
      end else if (rd) begin
         chk("rd_pulses", 32'(rdy_n), 32'd1);
         chk("rd_cycle", 32'(at_k), 32'(resp_k));
         chk("rd_data", 32'(seen), 32'(exp_rd));
         chk("rd_hold", 32'(bad_hold), 32'd0);
         chk("rd_other_pulses", 32'(ack_n + err_n), 32'd0);
`ifdef MEM_STATS_EN
         n_rd++;
`endif
      end else begin
         chk("wr_pulses", 32'(ack_n), 32'd1);
         chk("wr_cycle", 32'(at_k), 32'(resp_k));
         chk("wr_other_pulses", 32'(rdy_n + err_n), 32'd0);
         model_mem[i] = wval;
         known_q.push_back(i);
`ifdef MEM_STATS_EN
         n_wr++;
`endif
      end
   endtask

   initial begin
      int          pulses;
      int          op;
      logic [7:0]  ri;
      logic [15:0] ra;
      logic [15:0] rv;

      reset       = 1'b1;
      bus.readM   = 1'b0;
      bus.writeM  = 1'b0;
      bus.address = '0;
      cpu_en      = 1'b0;
      cpu_val     = '0;
`ifdef MEM_STATS_EN
      n_rd = 0;
      n_wr = 0;
`endif
      repeat (3) @(negedge clk);
      chk("reset_inputReady", 32'(bus.inputReady), 32'd0);
      chk("reset_ackOutput", 32'(bus.ackOutput), 32'd0);
      chk("reset_err", 32'(bus.err), 32'd0);
      zchk("reset_bus_release");
`ifdef MEM_STATS_EN
      chk("reset_rd_count", 32'(rd_count), 32'd0);
      chk("reset_wr_count", 32'(wr_count), 32'd0);
`endif
      reset = 1'b0;
      @(negedge clk);

      // Write then read back with the request held three cycles past the pulse.
      txn(1'b0, 1'b1, 16'h0010, 16'hBEEF, 0);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 3);

      // Upper address bits alias onto the same index.
      txn(1'b0, 1'b1, 16'h0105, 16'h1234, 0);
      txn(1'b1, 1'b0, 16'h0005, 16'h0000, 0);

      // Simultaneous read and write: err only, array untouched.
      txn(1'b1, 1'b1, 16'h0010, 16'h5555, 0);
      txn(1'b1, 1'b0, 16'h0010, 16'h0000, 1);

      // Reset lands on the edge that would have committed the write.
      bus.writeM  = 1'b1;
      bus.address = 16'h0005;
      cpu_val     = 16'hAAAA;
      cpu_en      = 1'b1;
      pulses      = 0;
      for (int k = 1; k <= LAT; k++) begin
         @(negedge clk);
         pulses += int'(bus.ackOutput) + int'(bus.inputReady);
      end
      reset      = 1'b1;
      bus.writeM = 1'b0;
      cpu_en     = 1'b0;
      @(negedge clk);
      reset = 1'b0;
`ifdef MEM_STATS_EN
      n_rd = 0;
      n_wr = 0;
`endif
      for (int k = 0; k < 3; k++) begin
         pulses += int'(bus.ackOutput) + int'(bus.inputReady);
         @(negedge clk);
      end
      chk("abort_no_pulse", 32'(pulses), 32'd0);
      zchk("abort_bus_release");
      txn(1'b1, 1'b0, 16'h0005, 16'h0000, 0);

      // Randomized traffic against the model.
      for (int n = 0; n < 40; n++) begin
         op = int'($urandom_range(0, 9));
         rv = 16'($urandom);
         if (op == 0) begin
            ra = 16'($urandom);
            txn(1'b1, 1'b1, ra, rv, int'($urandom_range(0, 2)));
         end else if (op <= 4) begin
            ra = 16'($urandom);
            txn(1'b0, 1'b1, ra, rv, int'($urandom_range(0, 2)));
         end else begin
            ri = known_q[$urandom_range(0, known_q.size() - 1)];
            ra = {8'($urandom), ri};
            txn(1'b1, 1'b0, ra, 16'h0000, int'($urandom_range(0, 3)));
         end
      end

`ifdef MEM_STATS_EN
      chk("stats_rd_count", 32'(rd_count), 32'(n_rd));
      chk("stats_wr_count", 32'(wr_count), 32'(n_wr));
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      chk("stats_rd_cleared", 32'(rd_count), 32'd0);
      chk("stats_wr_cleared", 32'(wr_count), 32'd0);
`endif

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the CPU memory handshake (readM/writeM/address/data/inputReady/ackOutput).
- Accepts one request at a time, models a configurable access latency and holds a word-addressed storage array.
- For reads: drives the shared tri-state `data` bus and pulses `inputReady`.
- For writes: captures the bus and pulses `ackOutput`.
- Sits at the memory end of the CPU testbench and system top.

Parameters:
- WORD_SIZE, 16, data and address width in bits.
- ADDR_BITS, 8, index bits; depth = 2**ADDR_BITS words.
- LATENCY, 2, cycles from request acceptance to response pulse; legal range 1..15.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- readM  input  1  CPU read request; held high until the request is released.
- writeM  input  1  CPU write request; held high until the request is released.
- address  input  WORD_SIZE  word address.
- data  inout  WORD_SIZE  shared data bus; driven by the CPU on writes and by this block on read responses, otherwise Z from this block.
- inputReady  output  1  one-cycle pulse: read data valid on `data`.
- ackOutput  output  1  one-cycle pulse: write committed.
- err  output  1  one-cycle pulse: readM and writeM both high in IDLE.

Behaviour:
- Reset (clk edge with reset=1):
  - state=IDLE; inputReady=0, ackOutput=0, err=0; data released to Z; latency counter=0.
  - Array contents are NOT cleared.
  - Reset mid-operation aborts the transaction: no pulse, no array write.
- States: IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, RELEASE.
- IDLE:
  - readM=1, writeM=0 at edge T0 → latch address[ADDR_BITS-1:0]; load counter=LATENCY-1; go to RD_WAIT.
  - writeM=1, readM=0 → latch the index and the `data` bus value; load counter; go to WR_WAIT.
  - Both high → err=1 for one cycle; no access; go to RELEASE.
- RD_WAIT / WR_WAIT:
  - Counter decrements each edge.
  - On the edge where the counter is 0 → RD_RESP / WR_RESP.
  - The response pulse is therefore registered high during the cycle after edge T0+LATENCY.
- RD_RESP:
  - inputReady=1 for exactly one cycle.
  - `data` = array[latched index], read at the response edge, so an earlier write to the same index is visible.
  - Next state RELEASE.
- WR_RESP:
  - The array write occurs at the edge entering WR_RESP.
  - ackOutput=1 for exactly one cycle; next state RELEASE.
- RELEASE:
  - `data` stays driven (read case) while readM=1.
  - Once readM=0 and writeM=0 are sampled → IDLE, bus Z.
  - A new request is accepted no earlier than the edge after that return to IDLE.
- Request dropped during RD_WAIT or WR_WAIT: the transaction still completes and pulses; the bench treats this as a protocol violation.
- Address wrap: upper address bits above ADDR_BITS are ignored; e.g. with ADDR_BITS=8, 0x0105 aliases 0x05.
- The bus driver is enabled only in RD_RESP, and in RELEASE following a read. It is never enabled during a write.

Optional Feature:
- MEM_STATS_EN.
- Defined:
  - Adds outputs rd_count[15:0] and wr_count[15:0].
  - Each increments by 1 on every inputReady / ackOutput pulse, wrapping 0xFFFF→0x0000.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- Package mem_if_pkg holds:
  - WORD_SIZE default;
  - state enum mem_state_t {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP, RELEASE};
  - HIGHZ_WORD constant.
- Sub-module mem_array: synchronous single-port write, combinational read, DEPTH=2**ADDR_BITS, no reset.
- mem_responder contains the FSM, latency counter, tri-state driver and optional stats.

Test Plan:
- Write then read: write 0xBEEF to 0x0010 with LATENCY=2.
  - ackOutput pulses high during the cycle after edge T0+2.
  - A following read of 0x0010 pulses inputReady with data=0xBEEF.
- Read hold: readM held 3 cycles after the inputReady pulse.
  - data stays 0xBEEF until the cycle after readM falls, then Z.
  - No second inputReady pulse.
- Address wrap: write 0x1234 to 0x0105, read 0x0005 → data=0x1234.
- Simultaneous request: readM=writeM=1 in IDLE.
  - err pulses once; no inputReady or ackOutput.
  - Array unchanged: reading the targeted index returns its old value.
- Reset mid-write: reset asserted in WR_WAIT.
  - No ackOutput pulse; the target word keeps its previous value.
  - Bus Z; the next read completes normally.
- MEM_STATS_EN defined: 3 writes and 2 reads → wr_count=3, rd_count=2; both return to 0 after reset.
